hex_scan_display: RTL and testbench

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/hex_disp_pkg.sv | 18 +
 rtl/hex7seg_decode.sv | 14 +
 rtl/hex_scan_display.sv | 104 ++++++++++
 tb/tb_hex_scan_display.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared constants for the multiplexed hex display.
// Holds the digit count, the all-segments-off pattern, and the active-low
// seven-segment table (bit 0 = a ... bit 6 = g, bit 7 = dp kept off).
package hex_disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the pattern for hex digit n; index 0 is the rightmost element.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
    8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational nibble to active-low segment pattern.
module hex7seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  // Table lookup; dp bit comes from the table and is always off.
  always_comb begin
    o_seg = SEG_TABLE[i_nibble];
  end

endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed driver for an 8-digit hex display.
// A prescaler holds each digit for SCAN_DIV cycles; the first BLANK cycles
// of every slot force all segments off to suppress ghosting.
// Optional build macro LEADING_ZERO_BLANK_EN: blank digits whose nibble and
// all more significant nibbles are zero (digit 0 always shown).
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  output logic [2:0]  which,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam int          CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [31:0] BLANK_U = BLANK;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_cap;
  logic [2:0]       r_which;
  logic [7:0]       r_seg;
  logic             r_frame;

  logic             w_slot_end;
  logic             w_in_blank;
  logic             w_lz_blank;
  logic [3:0]       w_nibble;
  logic [7:0]       w_pattern;
  logic [31:0]      w_upper;

  // Slot bookkeeping and nibble selection for the digit currently scanned.
  always_comb begin
    w_slot_end = (r_cnt == CNT_LAST);
    w_in_blank = ({{(32-CNT_W){1'b0}}, r_cnt} < BLANK_U);
    w_nibble   = r_cap[{r_idx, 2'b00} +: 4];
    w_upper    = r_cap >> {r_idx, 2'b00};
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a leading zero: this nibble and everything above it are zero.
  always_comb begin
    w_lz_blank = (r_idx != 3'd0) && (w_upper == 32'd0);
  end
`else
  // Every digit is always decoded in the default build.
  always_comb begin
    w_lz_blank = 1'b0;
  end
`endif

  hex7seg_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_pattern)
  );

  // Prescaler and digit index; the scan free-runs and load never disturbs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture register follows data on every edge where load is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap <= 32'd0;
    end else if (load) begin
      r_cap <= data;
    end
  end

  // Registered outputs, one cycle behind the scan position. frame marks the
  // cycle where which first shows 0 after having shown 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_which <= 3'd0;
      r_seg   <= SEG_OFF;
      r_frame <= 1'b0;
    end else begin
      r_which <= r_idx;
      r_seg   <= (w_in_blank || w_lz_blank) ? SEG_OFF : w_pattern;
      r_frame <= (r_idx == 3'd0) && (r_which == 3'(NUM_DIGITS - 1));
    end
  end

  assign which = r_which;
  assign seg   = r_seg;
  assign frame = r_frame;

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: scoreboard bench for hex_scan_display with
// SCAN_DIV=4, BLANK=1. Stimulus pushes the expected output for every clock
// edge it issues; the monitor pops and compares on the following falling
// edge (or immediately on chk_ev for reset checks made between edges).
module tb_hex_scan_display;

  localparam int TB_DIV   = 4;
  localparam int TB_BLANK = 1;

  typedef struct {
    logic [2:0] which;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        load;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic        frame;

  exp_t        q[$];
  event        chk_ev;
  int          n_pass   = 0;
  int          n_checks = 0;
  int          n_direct_fail = 0;
  int          m        = 0;
  logic [31:0] cap      = 32'd0;

  hex_scan_display #(.SCAN_DIV(TB_DIV), .BLANK(TB_BLANK)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .load  (load),
    .which (which),
    .seg   (seg),
    .frame (frame)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex_pat(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Expected output after the edge that leaves scan step mm (steps counted
  // from reset release), given the capture value held before that edge.
  function automatic exp_t model(input int mm, input logic [31:0] c);
    exp_t e;
    int   slot;
    int   ph;
    logic lz;
    slot    = (mm / TB_DIV) % 8;
    ph      = mm % TB_DIV;
    e.which = 3'(slot);
    e.frame = (mm % (8 * TB_DIV) == 0) && (mm != 0);
    lz      = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lz      = (slot != 0) && ((c >> (slot * 4)) == 32'd0);
`endif
    e.seg   = (ph < TB_BLANK || lz) ? 8'hFF : hex_pat(c[slot*4 +: 4]);
    return e;
  endfunction

  task automatic step(input logic ld, input logic [31:0] d);
    exp_t e;
    load = ld;
    data = d;
    e    = model(m, cap);
    @(posedge clk);
    q.push_back(e);
    if (ld) cap = d;
    m++;
    #1;
  endtask

  task automatic check_reset_now(input string tag);
    exp_t e;
    if (which !== 3'd0) begin
      n_direct_fail++;
      $display("FAIL %s t=%0t: which=%0d during reset, want 0", tag, $time, which);
    end
    if (seg !== 8'hFF) begin
      n_direct_fail++;
      $display("FAIL %s t=%0t: seg=%h during reset, want FF", tag, $time, seg);
    end
    if (frame !== 1'b0) begin
      n_direct_fail++;
      $display("FAIL %s t=%0t: frame=%b during reset, want 0", tag, $time, frame);
    end
    e.which = 3'd0;
    e.seg   = 8'hFF;
    e.frame = 1'b0;
    q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  // Monitor: compare whatever expectation is pending.
  always @(negedge clk or chk_ev) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (which === e.which && seg === e.seg && frame === e.frame) begin
        n_pass++;
      end else begin
        $display("FAIL out#%0d t=%0t: got which=%0d seg=%h frame=%b, want which=%0d seg=%h frame=%b",
                 n_checks, $time, which, seg, frame, e.which, e.seg, e.frame);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_now("reset_hold");
    #2;
    rst = 1'b0;
    m   = 0;
    cap = 32'd0;

    // Free run from reset: blank then C0 in every slot, frame every 32 cycles.
    repeat (70) step(1'b0, 32'd0);

    // Decode of a full pattern.
    step(1'b1, 32'hFEDC_BA98);
    repeat (40) step(1'b0, 32'd0);

    // Load on the edge where the index advances 0->1.
    while (m % (8 * TB_DIV) != TB_DIV - 1) step(1'b0, 32'd0);
    step(1'b1, 32'h0000_0001);
    repeat (70) step(1'b0, 32'hFFFF_FFFF);

    // Asynchronous reset mid-slot, checked between edges.
    while (m % TB_DIV != 2) step(1'b0, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_now("async_rst");
    @(posedge clk);
    #1;
    check_reset_now("rst_held_edge");
    rst = 1'b0;
    m   = 0;
    cap = 32'd0;
    repeat (40) step(1'b0, 32'd0);

    // Leading-zero pattern and all-zero data.
    step(1'b1, 32'h0000_0A05);
    repeat (34) step(1'b0, 32'd0);
    step(1'b1, 32'h0000_0000);
    repeat (34) step(1'b0, 32'd0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_checks > 0 && n_pass == n_checks && n_direct_fail == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL: %0d scoreboard mismatches, %0d direct reset mismatches",
               n_checks - n_pass, n_direct_fail);
    end
    $finish;
  end

endmodule
